// File: rtl/bn_res_ctrl.sv
// -----------------------------------------------------------------------------
// bn_res_ctrl
// Frame sequencer for the BN + residual datapath. After a start pulse it asks
// the parameter loader for bn_a/bn_b. It then admits FM_WIDTH*FM_HEIGHT
// partial-sum pixels under credit flow control toward the RPReLU input FIFO,
// and issues the matching residual-buffer reads. When every datapath output
// has been counted it pulses frame_done. No pixel data passes through here.
//
// Ports
//   clk, rstn          : clock; synchronous active-high reset
//   start, res_en      : frame start pulse (IDLE only); residual enable sampled on start
//   param_load_req/done: one-cycle request to the BN parameter loader / its completion pulse
//   psum_valid/ready   : partial-sum handshake
//   bn_data_in_valid   : datapath input strobe (= psum_valid & psum_ready)
//   bn_data_out_valid  : datapath output strobe, counted toward frame end
//   res_rd_en/addr     : residual buffer read (one-cycle read latency)
//   res_zero           : forces the datapath residual operand to zero
//   credit_return      : downstream FIFO released one slot
//   busy, frame_done   : FSM not idle; one-cycle end-of-frame pulse
//   credit_err         : sticky protocol error, cleared by reset or start
// -----------------------------------------------------------------------------
module bn_res_ctrl #(
   parameter int unsigned FM_WIDTH   = 32,
   parameter int unsigned FM_HEIGHT  = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned CREDIT_MAX = 4,
   parameter int unsigned CNT_WIDTH  = 11
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  res_en,
   output logic                  param_load_req,
   input  logic                  param_load_done,
   input  logic                  psum_valid,
   output logic                  psum_ready,
   output logic                  bn_data_in_valid,
   input  logic                  bn_data_out_valid,
   output logic                  res_rd_en,
   output logic [ADDR_WIDTH-1:0] res_rd_addr,
   output logic                  res_zero,
   input  logic                  credit_return,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  credit_err
);

   localparam int unsigned          TOTAL_INT = FM_WIDTH * FM_HEIGHT;
   localparam logic [CNT_WIDTH-1:0] TOTAL     = CNT_WIDTH'(TOTAL_INT);
   localparam logic [CNT_WIDTH-1:0] COL_LAST  = CNT_WIDTH'(FM_WIDTH - 1);
   localparam int unsigned          CRW       = $clog2(CREDIT_MAX + 1);
   localparam logic [CRW-1:0]       CRED_FULL = CRW'(CREDIT_MAX);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               state_q,   state_d;
   logic [CNT_WIDTH-1:0] in_cnt_q,  in_cnt_d;
   logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
   logic [CNT_WIDTH-1:0] row_q,     row_d;
   logic [CNT_WIDTH-1:0] col_q,     col_d;
   logic [CRW-1:0]       credit_q,  credit_d;
   logic                 res_en_q,  res_en_d;
   logic                 err_q,     err_d;
   logic                 req_q,     req_d;
   logic                 done_q,    done_d;

   logic                 fire_s;
   logic                 out_err_s;
   logic                 cred_err_s;

   // Handshake and control outputs decoded from state and counters
   always_comb begin
      psum_ready       = (state_q == S_RUN) && (credit_q != '0) && (in_cnt_q < TOTAL);
      fire_s           = psum_valid & psum_ready;
      bn_data_in_valid = fire_s;
      res_rd_en        = fire_s & res_en_q;
      // Address from the pre-increment row/col so the residual arrives with the product register
      res_rd_addr      = ADDR_WIDTH'((32'(row_q) * 32'(FM_WIDTH)) + 32'(col_q));
      busy             = (state_q != S_IDLE);
      res_zero         = (state_q != S_IDLE) & ~res_en_q;
      param_load_req   = req_q;
      frame_done       = done_q;
      credit_err       = err_q;
   end

   // Next-state logic: FSM, pixel counters, credit counter and error flag
   always_comb begin
      state_d    = state_q;
      in_cnt_d   = in_cnt_q;
      out_cnt_d  = out_cnt_q;
      row_d      = row_q;
      col_d      = col_q;
      credit_d   = credit_q;
      res_en_d   = res_en_q;
      err_d      = err_q;
      req_d      = 1'b0;
      done_d     = 1'b0;
      out_err_s  = 1'b0;
      cred_err_s = 1'b0;

      // Outputs are counted before the FSM so DRAIN can leave on the cycle the last one appears
      if (bn_data_out_valid) begin
         if ((state_q != S_IDLE) && (out_cnt_q != TOTAL)) begin
            out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
         end else begin
            out_err_s = 1'b1;
         end
      end else begin
         out_err_s = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_LOAD;
               res_en_d  = res_en;
               err_d     = 1'b0;
               req_d     = 1'b1;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               row_d     = '0;
               col_d     = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (param_load_done) begin
               state_d = S_RUN;
            end else begin
               state_d = S_LOAD;
            end
         end
         S_RUN: begin
            if (fire_s) begin
               in_cnt_d = in_cnt_q + CNT_WIDTH'(1);
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_q + CNT_WIDTH'(1);
               end else begin
                  col_d = col_q + CNT_WIDTH'(1);
               end
               if (in_cnt_d == TOTAL) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            if (out_cnt_d == TOTAL) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A fire and a return in the same cycle cancel; a return into a full pool is dropped
      case ({fire_s, credit_return})
         2'b10: begin
            credit_d = credit_q - CRW'(1);
         end
         2'b01: begin
            if (credit_q == CRED_FULL) begin
               cred_err_s = 1'b1;
            end else begin
               credit_d = credit_q + CRW'(1);
            end
         end
         default: begin
            credit_d = credit_q;
         end
      endcase

      // Error events are applied after the start clear so a same-cycle event still sticks
      err_d = err_d | out_err_s | cred_err_s;
   end

   // State register with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q   <= S_IDLE;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         row_q     <= '0;
         col_q     <= '0;
         credit_q  <= CRED_FULL;
         res_en_q  <= 1'b0;
         err_q     <= 1'b0;
         req_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         row_q     <= row_d;
         col_q     <= col_d;
         credit_q  <= credit_d;
         res_en_q  <= res_en_d;
         err_q     <= err_d;
         req_q     <= req_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_bn_res_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bn_res_ctrl
// Scoreboard bench for bn_res_ctrl. The driver issues stimulus, emulates the
// 2-cycle datapath and the credit-returning FIFO, and runs a count-based
// reference model. The model pushes expected fires, loader requests,
// frame-done pulses and per-cycle status into queues. A separate monitor
// pops and compares whenever the DUT presents the corresponding output.
// -----------------------------------------------------------------------------
module tb_bn_res_ctrl;

   localparam int W     = 32;
   localparam int H     = 32;
   localparam int TOTAL = W * H;
   localparam int CMAX  = 4;

   logic       clk = 1'b0;
   logic       rstn, start, res_en, param_load_done, psum_valid;
   logic       bn_data_out_valid, credit_return;
   logic       param_load_req, psum_ready, bn_data_in_valid, res_rd_en;
   logic [9:0] res_rd_addr;
   logic       res_zero, busy, frame_done, credit_err;

   always #5 clk = ~clk;

   bn_res_ctrl #(
      .FM_WIDTH(W), .FM_HEIGHT(H), .ADDR_WIDTH(10), .CREDIT_MAX(CMAX), .CNT_WIDTH(11)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .res_en(res_en),
      .param_load_req(param_load_req), .param_load_done(param_load_done),
      .psum_valid(psum_valid), .psum_ready(psum_ready),
      .bn_data_in_valid(bn_data_in_valid), .bn_data_out_valid(bn_data_out_valid),
      .res_rd_en(res_rd_en), .res_rd_addr(res_rd_addr), .res_zero(res_zero),
      .credit_return(credit_return), .busy(busy), .frame_done(frame_done),
      .credit_err(credit_err)
   );

   typedef struct {
      int cyc;
      int addr;
      bit rd;
   } fire_t;

   fire_t      fire_q[$];
   int         req_q[$];
   int         done_q[$];
   logic [3:0] vec_q[$];

   int n_err = 0;
   int n_chk = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   // stimulus controls (one-shots are cleared after each cycle)
   bit pv_hold = 1'b0, pv_rand = 1'b0, auto_cr = 1'b1;
   bit start_drv = 1'b0, pld_drv = 1'b0, cr_man = 1'b0, rst_drv = 1'b0, res_drv = 1'b0;
   bit po[2];   // datapath delay line (fire -> output)
   bit pc[2];   // FIFO delay line (output -> credit return)

   // reference model
   bit m_busy, m_params, m_res, m_err;
   int m_acc, m_emit, m_credit, m_done_at;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_params = 1'b0; m_res = 1'b0; m_err = 1'b0;
      m_acc = 0; m_emit = 0; m_credit = CMAX; m_done_at = -1;
      po[0] = 1'b0; po[1] = 1'b0; pc[0] = 1'b0; pc[1] = 1'b0;
   endtask

   task automatic cycle();
      bit pv, ov, cr, rdy, ef, was_busy;
      @(negedge clk);
      cyc++;
      pv = pv_rand ? ($urandom_range(0, 3) != 0) : pv_hold;
      ov = po[1];
      cr = (auto_cr & pc[1]) | cr_man;
      rstn              = rst_drv;
      start             = start_drv;
      param_load_done   = pld_drv;
      psum_valid        = pv;
      bn_data_out_valid = ov;
      credit_return     = cr;
      res_en            = start_drv ? res_drv : 1'($urandom_range(0, 1));
      #1;
      rdy = m_busy && m_params && (m_acc < TOTAL) && (m_credit > 0);
      ef  = pv & rdy;
      if (chk_en) begin
         vec_q.push_back({m_busy, m_busy & ~m_res, rdy, m_err});
         if (ef) fire_q.push_back('{cyc, m_acc, m_res});
      end
      // environment reacts to the DUT's real handshake
      pc[1] = pc[0]; pc[0] = ov & auto_cr;
      po[1] = po[0]; po[0] = (bn_data_in_valid === 1'b1);
      if (rst_drv) begin
         model_reset();
      end else begin
         was_busy = m_busy;
         if (!was_busy && start_drv) begin
            m_busy = 1'b1; m_params = 1'b0; m_res = res_drv; m_err = 1'b0;
            m_acc = 0; m_emit = 0; m_done_at = -1;
            if (chk_en) req_q.push_back(cyc + 1);
         end else if (was_busy && !m_params && pld_drv) begin
            m_params = 1'b1;
         end
         if (ef) m_acc++;
         if (ov) begin
            if (was_busy && m_emit < TOTAL) begin
               m_emit++;
               if (m_emit == TOTAL) begin
                  m_done_at = cyc + 1;
                  if (chk_en) done_q.push_back(cyc + 1);
               end
            end else begin
               m_err = 1'b1;
            end
         end
         if (ef && !cr) m_credit--;
         else if (cr && !ef) begin
            if (m_credit == CMAX) m_err = 1'b1;
            else m_credit++;
         end
         if (was_busy && cyc == m_done_at) m_busy = 1'b0;
      end
      start_drv = 1'b0; pld_drv = 1'b0; cr_man = 1'b0; rst_drv = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic ret(input int n);
      repeat (n) begin
         cr_man = 1'b1;
         cycle();
      end
   endtask

   task automatic start_frame(input bit res, input int dly);
      start_drv = 1'b1; res_drv = res;
      cycle();
      repeat (dly - 1) cycle();
      pld_drv = 1'b1;
      cycle();
   endtask

   task automatic wait_idle(input int limit);
      int k = 0;
      while (m_busy && k < limit) begin
         cycle();
         k++;
      end
      n_chk++;
      if (m_busy) begin
         n_err++;
         $display("FAIL frame_timeout: still busy after %0d cycles", limit);
      end
   endtask

   // monitor: pops expectations whenever the DUT shows the matching output
   initial begin
      fire_t f;
      int    e;
      forever begin
         @(negedge clk);
         #2;
         if (chk_en) begin
            if (vec_q.size() > 0) check("status_busy_zero_ready_err",
                                        {busy, res_zero, psum_ready, credit_err}, vec_q.pop_front());
            if (bn_data_in_valid === 1'b1) begin
               f = (fire_q.size() > 0) ? fire_q.pop_front() : '{-1, -1, 1'b0};
               check("fire_cycle", cyc, f.cyc);
               check("res_rd_en", res_rd_en, f.rd);
               if (f.rd) check("res_rd_addr", res_rd_addr, f.addr);
            end else begin
               check("res_rd_en_no_fire", res_rd_en, 1'b0);
            end
            if (param_load_req === 1'b1) begin
               e = (req_q.size() > 0) ? req_q.pop_front() : -1;
               check("param_load_req_cycle", cyc, e);
            end
            if (frame_done === 1'b1) begin
               e = (done_q.size() > 0) ? done_q.pop_front() : -1;
               check("frame_done_cycle", cyc, e);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      model_reset();
      rst_drv = 1'b1; cycle();
      rst_drv = 1'b1; cycle();
      chk_en = 1'b1;
      run(3);                                   // reset state

      // full frame, residual on, continuous input, credits recycled by the FIFO
      pv_hold = 1'b1; auto_cr = 1'b1;
      start_frame(1'b1, 2);
      wait_idle(5000);
      run(6);

      // credit starvation, then a single return, then recovery
      auto_cr = 1'b0;
      start_frame(1'b1, 1);
      run(20);
      cr_man = 1'b1; cycle();
      cycle();
      pv_hold = 1'b0; run(4);
      ret(4);
      auto_cr = 1'b1; pv_hold = 1'b1;
      wait_idle(5000);
      run(6);

      // residual disabled, random input availability
      pv_rand = 1'b1;
      start_frame(1'b0, 3);
      wait_idle(8000);
      pv_rand = 1'b0;
      run(6);

      // simultaneous fire and return at credit 2, then overflow return at credit 4
      auto_cr = 1'b0; pv_hold = 1'b0;
      start_frame(1'b1, 1);
      pv_hold = 1'b1; run(2);
      pv_hold = 1'b0; run(4);
      pv_hold = 1'b1; cr_man = 1'b1; cycle();
      pv_hold = 1'b0; run(4);
      ret(2);
      ret(1);
      run(2);
      pv_hold = 1'b1; run(8);
      pv_hold = 1'b0; run(4);
      ret(4);
      auto_cr = 1'b1; pv_hold = 1'b1;
      wait_idle(5000);
      run(6);

      // reset in the middle of RUN
      start_frame(1'b1, 2);
      k = 0;
      while (m_acc < 300 && k < 5000) begin
         cycle();
         k++;
      end
      pv_hold = 1'b0; rst_drv = 1'b1; cycle();
      run(4);

      // new frame with stray start / load-done pulses
      pv_hold = 1'b1;
      start_drv = 1'b1; res_drv = 1'b1; cycle();
      start_drv = 1'b1; cycle();
      start_drv = 1'b1; cycle();
      pld_drv = 1'b1; cycle();
      run(10);
      pld_drv = 1'b1; cycle();
      k = 0;
      while (m_acc < TOTAL && k < 5000) begin
         cycle();
         k++;
      end
      start_drv = 1'b1; cycle();
      wait_idle(100);
      run(6);

      #5;
      chk_en = 1'b0;
      check("fires_outstanding", fire_q.size(), 0);
      check("param_load_req_outstanding", req_q.size(), 0);
      check("frame_done_outstanding", done_q.size(), 0);
      check("status_outstanding", vec_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
